// File: rtl/tq_pkg.sv
// Shared TQ datapath definitions: coefficient geometry, row-size codes and the
// lane-routing rule used by the butterfly pre-permutation.
package tq_pkg;

    localparam int TQ_DW    = 28;
    localparam int TQ_MAX_N = 32;

    typedef enum logic [1:0] {
        TQ_SZ4  = 2'd0,
        TQ_SZ8  = 2'd1,
        TQ_SZ16 = 2'd2,
        TQ_SZ32 = 2'd3
    } tq_size_e;

    // Returns the input lane that feeds output 'lane'. The row length clamps to max_n.
    function automatic int unsigned tq_src_lane(int unsigned lane, tq_size_e size,
                                                logic inverse, logic enable,
                                                int unsigned max_n);
        int unsigned n;
        int unsigned half;
        n = 32'd4 << size;
        if (n > max_n) n = max_n;
        half = n / 2;
        if (!enable || lane >= n) return lane;
        if (!inverse) return (lane >> 1) + (lane % 2) * half;
        if (lane < half) return 2 * lane;
        return 2 * (lane - half) + 1;
    endfunction

endpackage

// File: rtl/premuat_perm.sv
// Combinational butterfly pre-permutation of one row: forward interleave or
// inverse de-interleave over the first N lanes, identity elsewhere.
module premuat_perm
    import tq_pkg::*;
#(
    parameter int DW    = TQ_DW,
    parameter int MAX_N = TQ_MAX_N
) (
    input  logic [MAX_N*DW-1:0] row,
    input  tq_size_e            size,
    input  logic                inverse,
    input  logic                enable,
    output logic [MAX_N*DW-1:0] result
);

    localparam int IW = $clog2(MAX_N);

    logic [DW-1:0] lane [MAX_N];

    for (genvar k = 0; k < MAX_N; k++) begin : g_lane
        logic [IW-1:0] src;
        assign lane[k] = row[k*DW +: DW];
        assign src     = IW'(tq_src_lane(k, size, inverse, enable, MAX_N));
        assign result[k*DW +: DW] = lane[src];
    end

endmodule

// File: rtl/premuat_pipe.sv
// Two-stage pipelined butterfly pre-permutation with valid/ready flow control.
// Optional output-row counter enabled by defining TQ_PREMUAT_ROWCNT_EN.
module premuat_pipe
    import tq_pkg::*;
#(
    parameter int DW    = TQ_DW,
    parameter int MAX_N = TQ_MAX_N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_enable,
    input  logic                i_inverse,
    input  logic [1:0]          i_size,
    input  logic                i_last,
    input  logic [MAX_N*DW-1:0] i_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [MAX_N*DW-1:0] o_data,
    output logic [1:0]          o_size,
    output logic                o_last
`ifdef TQ_PREMUAT_ROWCNT_EN
    ,
    output logic [15:0]         o_row_cnt
`endif
);

    logic                s1_valid;
    logic [MAX_N*DW-1:0] s1_data;
    tq_size_e            s1_size;
    logic                s1_inverse;
    logic                s1_enable;
    logic                s1_last;
    logic [MAX_N*DW-1:0] perm_data;
    logic                s2_free;
    logic                s1_adv;
    logic                accept;

    // Each stage advances when its successor is empty or draining this cycle.
    assign s2_free = !o_valid || i_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign o_ready = !s1_valid || s1_adv;
    assign accept  = i_valid && o_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_size    <= TQ_SZ4;
            s1_inverse <= 1'b0;
            s1_enable  <= 1'b0;
            s1_last    <= 1'b0;
        end else begin
            if (o_ready) s1_valid <= i_valid;
            if (accept) begin
                s1_data    <= i_data;
                s1_size    <= tq_size_e'(i_size);
                s1_inverse <= i_inverse;
                s1_enable  <= i_enable;
                s1_last    <= i_last;
            end
        end
    end

    premuat_perm #(
        .DW    (DW),
        .MAX_N (MAX_N)
    ) u_perm (
        .row     (s1_data),
        .size    (s1_size),
        .inverse (s1_inverse),
        .enable  (s1_enable),
        .result  (perm_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_size  <= '0;
            o_last  <= 1'b0;
        end else if (s2_free) begin
            o_valid <= s1_valid;
            if (s1_adv) begin
                o_data <= perm_data;
                o_size <= s1_size;
                o_last <= s1_last;
            end
        end
    end

`ifdef TQ_PREMUAT_ROWCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 o_row_cnt <= '0;
        else if (o_valid && i_ready) o_row_cnt <= o_row_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_premuat_pipe.sv
// Self-checking bench for premuat_pipe: directed spot checks plus a randomized
// stream with random back-pressure, compared against an array-based row model.
module tb_premuat_pipe;

    localparam int DW    = 28;
    localparam int MAX_N = 32;
    localparam int W     = DW * MAX_N;
    localparam int ROWS  = 20;

    typedef logic [W-1:0] row_t;
    typedef struct {
        row_t       data;
        logic [1:0] size;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic       o_ready;
    logic       i_enable;
    logic       i_inverse;
    logic [1:0] i_size;
    logic       i_last;
    row_t       i_data;
    logic       o_valid;
    logic       i_ready;
    row_t       o_data;
    logic [1:0] o_size;
    logic       o_last;
`ifdef TQ_PREMUAT_ROWCNT_EN
    logic [15:0] o_row_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    premuat_pipe #(
        .DW    (DW),
        .MAX_N (MAX_N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_enable  (i_enable),
        .i_inverse (i_inverse),
        .i_size    (i_size),
        .i_last    (i_last),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_size    (o_size),
`ifdef TQ_PREMUAT_ROWCNT_EN
        .o_row_cnt (o_row_cnt),
`endif
        .o_last    (o_last)
    );

    // Row model written straight from the interleave equations.
    function automatic row_t model(row_t din, logic [1:0] sz, logic inv, logic en);
        logic [DW-1:0] a [MAX_N];
        logic [DW-1:0] b [MAX_N];
        row_t r;
        int n;
        n = 4 << sz;
        if (n > MAX_N) n = MAX_N;
        for (int i = 0; i < MAX_N; i++) a[i] = din[i*DW +: DW];
        b = a;
        if (en) begin
            for (int k = 0; k < n / 2; k++) begin
                if (!inv) begin
                    b[2*k]   = a[k];
                    b[2*k+1] = a[k + n/2];
                end else begin
                    b[k]       = a[2*k];
                    b[k + n/2] = a[2*k+1];
                end
            end
        end
        for (int i = 0; i < MAX_N; i++) r[i*DW +: DW] = b[i];
        return r;
    endfunction

    function automatic logic [31:0] lane_of(row_t r, int k);
        return 32'(r[k*DW +: DW]);
    endfunction

    function automatic row_t ramp(int base);
        row_t r;
        for (int i = 0; i < MAX_N; i++) r[i*DW +: DW] = DW'(base + i);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < MAX_N; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(string tag, row_t obs, row_t exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            fails++;
            bad = 0;
            for (int i = MAX_N - 1; i >= 0; i--)
                if (obs[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
            $error("FAIL %s lane %0d observed=%0h expected=%0h", tag, bad,
                   obs[bad*DW +: DW], exp[bad*DW +: DW]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(row_t d, logic [1:0] sz, logic inv, logic en, logic last);
        i_valid   = 1'b1;
        i_data    = d;
        i_size    = sz;
        i_inverse = inv;
        i_enable  = en;
        i_last    = last;
    endtask

    // One isolated beat with i_ready=1: checks 2-cycle latency, content and single emission.
    task automatic send_one(string tag, row_t d, logic [1:0] sz, logic inv, logic en,
                            logic last, output row_t got);
        i_ready = 1'b1;
        drive(d, sz, inv, en, last);
        step();
        i_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", 32'(o_valid), 32'd0);
        step();
        @(negedge clk);
        chk("lat_valid", 32'(o_valid), 32'd1);
        chk_row(tag, o_data, model(d, sz, inv, en));
        chk("size_carry", 32'(o_size), 32'(sz));
        chk("last_carry", 32'(o_last), 32'(last));
        got = o_data;
        step();
        @(negedge clk);
        chk("single_emit", 32'(o_valid), 32'd0);
        step();
    endtask

    initial begin
        row_t  r, rn, got, back;
        beat_t exp_q[$];
        beat_t bt;
        row_t  s_data [ROWS];
        logic  s_inv  [ROWS];
        logic  s_en   [ROWS];
        int    sent, recv, lasts;
        logic  hold_pending;
        row_t  held_data;
        logic [1:0] held_size;
        logic  held_last;
`ifdef TQ_PREMUAT_ROWCNT_EN
        logic [15:0] cnt_before;
`endif

        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_enable = 1'b0;
        i_inverse = 1'b0; i_size = 2'd0; i_last = 1'b0; i_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_size", 32'(o_size), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk_row("rst_data", o_data, '0);
`ifdef TQ_PREMUAT_ROWCNT_EN
        chk("rst_cnt", 32'(o_row_cnt), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(o_ready), 32'd1);
        step();

        r = ramp(0);
        send_one("fwd32", r, 2'd3, 1'b0, 1'b1, 1'b0, got);
        chk("fwd32_l1", lane_of(got, 1), 32'd16);
        chk("fwd32_l2", lane_of(got, 2), 32'd1);
        chk("fwd32_l30", lane_of(got, 30), 32'd15);
        chk("fwd32_l31", lane_of(got, 31), 32'd31);
        send_one("inv_of_fwd", got, 2'd3, 1'b1, 1'b1, 1'b0, back);
        chk_row("roundtrip", back, r);

        send_one("inv32", r, 2'd3, 1'b1, 1'b1, 1'b0, got);
        chk("inv32_l1", lane_of(got, 1), 32'd2);
        chk("inv32_l15", lane_of(got, 15), 32'd30);
        chk("inv32_l16", lane_of(got, 16), 32'd1);

        r = ramp(100);
        send_one("fwd8", r, 2'd1, 1'b0, 1'b1, 1'b0, got);
        chk("fwd8_l1", lane_of(got, 1), 32'd104);
        chk("fwd8_l6", lane_of(got, 6), 32'd103);
        chk("fwd8_l8", lane_of(got, 8), 32'd108);

        rn = rand_row();
        for (int i = 0; i < MAX_N; i++) begin
            if (i % 3 == 0)      rn[i*DW +: DW] = '1;
            else if (i % 3 == 1) rn[i*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
        end
        for (int m = 0; m < 8; m++) begin
            send_one("bypass", rn, 2'(m % 4), 1'(m / 4), 1'b0, 1'b1, got);
            chk_row("bypass_identity", got, rn);
        end
        chk("neg1_lane0", lane_of(got, 0), 32'h0FFF_FFFF);
        chk("negmin_lane1", lane_of(got, 1), 32'h0800_0000);

        for (int s = 0; s < 3; s++) begin
            r = rand_row();
            send_one("inv_small", r, 2'(s), 1'b1, 1'b1, 1'b0, got);
        end

        // Randomized stream under random back-pressure.
        for (int i = 0; i < ROWS; i++) begin
            s_data[i] = rand_row();
            s_inv[i]  = 1'($urandom_range(0, 1));
            s_en[i]   = ($urandom_range(0, 3) != 0);
        end
        sent = 0; recv = 0; lasts = 0; hold_pending = 1'b0;
        held_data = '0; held_size = '0; held_last = 1'b0;
`ifdef TQ_PREMUAT_ROWCNT_EN
        cnt_before = o_row_cnt;
`endif
        for (int cyc = 0; cyc < 600 && recv < ROWS; cyc++) begin
            if (sent < ROWS)
                drive(s_data[sent], 2'(sent % 4), s_inv[sent], s_en[sent], sent == ROWS - 1);
            else
                i_valid = 1'b0;
            i_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold_pending) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk_row("stall_data", o_data, held_data);
                chk("stall_size", 32'(o_size), 32'(held_size));
                chk("stall_last", 32'(o_last), 32'(held_last));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra_beat", 32'd1, 32'd0);
                end else begin
                    bt = exp_q.pop_front();
                    chk_row("stream_row", o_data, bt.data);
                    chk("stream_size", 32'(o_size), 32'(bt.size));
                    chk("stream_last", 32'(o_last), 32'(bt.last));
                end
                if (o_last) lasts++;
                recv++;
            end
            hold_pending = o_valid && !i_ready;
            held_data = o_data; held_size = o_size; held_last = o_last;
            if (i_valid && o_ready) begin
                bt.data = model(s_data[sent], 2'(sent % 4), s_inv[sent], s_en[sent]);
                bt.size = 2'(sent % 4);
                bt.last = (sent == ROWS - 1);
                exp_q.push_back(bt);
                sent++;
            end
            step();
        end
        i_valid = 1'b0;
        chk("stream_received", 32'(recv), 32'(ROWS));
        chk("stream_sent", 32'(sent), 32'(ROWS));
        chk("stream_last_count", 32'(lasts), 32'd1);
`ifdef TQ_PREMUAT_ROWCNT_EN
        chk("stream_cnt", 32'(o_row_cnt), 32'(cnt_before + 16'(ROWS)));
`endif

        // Reset with two beats in flight.
        i_ready = 1'b1;
        drive(rand_row(), 2'd2, 1'b0, 1'b1, 1'b1);
        step();
        drive(rand_row(), 2'd3, 1'b1, 1'b1, 1'b1);
        step();
        i_valid = 1'b0;
        @(negedge clk);
        chk("inflight_valid", 32'(o_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(o_valid), 32'd0);
        chk_row("rst_async_data", o_data, '0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_ready", 32'(o_ready), 32'd1);
        chk("rst2_valid", 32'(o_valid), 32'd0);
        step();
        @(negedge clk);
        chk("no_ghost", 32'(o_valid), 32'd0);
        step();
`ifdef TQ_PREMUAT_ROWCNT_EN
        chk("rst2_cnt", 32'(o_row_cnt), 32'd0);
`endif
        r = rand_row();
        send_one("after_reset", r, 2'd0, 1'b0, 1'b1, 1'b0, got);
`ifdef TQ_PREMUAT_ROWCNT_EN
        chk("cnt_one", 32'(o_row_cnt), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
